// File: rtl/lcd_sequencer_if.sv
// Host-side signal bundle of the LCD sequencer: refresh control, host command
// handshake and the command word / status driven toward the display datapath.
interface lcd_sequencer_if;
  logic        i_refresh_en;
  logic [6:0]  i_addr;
  logic        i_req;
  logic [7:0]  i_cmd;
  logic        o_ack;
  logic [10:0] o_comm;
  logic        o_ready;
  logic        o_busy;

  modport master (
    output i_refresh_en, i_addr, i_req, i_cmd,
    input  o_ack, o_comm, o_ready, o_busy
  );

  modport slave (
    input  i_refresh_en, i_addr, i_req, i_cmd,
    output o_ack, o_comm, o_ready, o_busy
  );
endinterface

// File: rtl/lcd_sequencer.sv
// HD44780 command sequencer: power-up wait, init sequence, periodic frame refresh
// (set-address + SIZE slot writes) and host commands merged between frames.
module lcd_sequencer #(
  parameter int SIZE      = 4,
  parameter int T_PWR     = 750000,
  parameter int T_CMD     = 2000,
  parameter int T_CLR     = 82000,
  parameter int T_REFRESH = 500000,
  parameter int CW        = 20
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  lcd_sequencer_if.slave   bus
);

  localparam logic [10:0]   IDLE    = 11'h200;
  localparam logic [CW-1:0] PWR_LD  = CW'(T_PWR);
  localparam logic [CW-1:0] CMD_M1  = CW'(T_CMD - 1);
  localparam logic [CW-1:0] CLR_M1  = CW'(T_CLR - 1);
  localparam logic [CW-1:0] REF_LD  = CW'(T_REFRESH);
  localparam logic [8:0]    N_SLOTS = 9'(SIZE);
  localparam logic [8:0]    N_INIT  = 9'd4;

  typedef enum logic [2:0] {
    S_PWR, S_INIT, S_HUB, S_USER, S_ADDR, S_DATA
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [CW-1:0] gap, gap_d;
  logic [8:0]    idx, idx_d;
  logic          ready_d;
  logic          issue;
  logic          ack_d;
  logic [10:0]   word;

  function automatic logic [7:0] init_byte(input logic [1:0] i);
    case (i)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h06;
      default: return 8'h01;
    endcase
  endfunction

  // Clear and home need the long settle time; data slot indices never do.
  function automatic logic [CW-1:0] spacing_m1(input logic [10:0] w);
    if (!w[10] && (w[7:0] inside {8'h01, 8'h02, 8'h03})) return CLR_M1;
    return CMD_M1;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_PWR;
      cnt         <= PWR_LD;
      gap         <= '0;
      idx         <= '0;
      bus.o_ready <= 1'b0;
      bus.o_comm  <= IDLE;
      bus.o_ack   <= 1'b0;
      bus.o_busy  <= 1'b1;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      gap         <= gap_d;
      idx         <= idx_d;
      bus.o_ready <= ready_d;
      bus.o_comm  <= word;
      bus.o_ack   <= ack_d;
      bus.o_busy  <= (state_d != S_HUB);
    end
  end

  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    issue = 1'b0;
    ack_d = 1'b0;
    word  = IDLE;
    unique case (state)
      S_INIT: if (cnt == '0 && idx < N_INIT) begin
        issue = 1'b1;
        word  = {3'b000, init_byte(idx[1:0])};
      end
      S_HUB: begin
        if (bus.i_req) begin
          issue = 1'b1;
          ack_d = 1'b1;
          word  = {3'b000, bus.i_cmd};
        end else if (bus.i_refresh_en && gap == '0) begin
          issue = 1'b1;
          word  = {4'b0001, bus.i_addr};
        end
      end
      S_ADDR: if (cnt == '0) begin
        issue = 1'b1;
        word  = {3'b101, 8'd0};
      end
      S_DATA: if (cnt == '0 && idx < N_SLOTS) begin
        issue = 1'b1;
        word  = {3'b101, idx[7:0]};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    gap_d   = gap;
    idx_d   = idx;
    ready_d = bus.o_ready;
    if (issue) cnt_d = spacing_m1(word);
    unique case (state)
      S_PWR: begin
        if (cnt <= CW'(1)) begin
          state_d = S_INIT;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      S_INIT: begin
        if (issue) begin
          idx_d = idx + 9'd1;
        end else if (cnt != '0) begin
          cnt_d = cnt - CW'(1);
        end else begin
          state_d = S_HUB;
          ready_d = 1'b1;
          gap_d   = '0;
        end
      end
      S_HUB: begin
        if (issue) begin
          state_d = ack_d ? S_USER : S_ADDR;
        end else if (gap != '0) begin
          gap_d = gap - CW'(1);
        end
      end
      S_USER: begin
        if (cnt != '0) cnt_d = cnt - CW'(1);
        else           state_d = S_HUB;
      end
      S_ADDR: begin
        if (issue) begin
          state_d = S_DATA;
          idx_d   = 9'd1;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      S_DATA: begin
        if (issue) begin
          idx_d = idx + 9'd1;
        end else if (cnt != '0) begin
          cnt_d = cnt - CW'(1);
        end else begin
          state_d = S_HUB;
          gap_d   = REF_LD;
        end
      end
      default: state_d = S_PWR;
    endcase
  end

endmodule

// File: tb/tb_lcd_sequencer.sv
// Directed bench for lcd_sequencer with short timing parameters; expected
// words and cycle distances are hand-derived constants.
module tb_lcd_sequencer;

  localparam logic [10:0] IDLE = 11'h200;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  lcd_sequencer_if bus();

  lcd_sequencer #(
    .SIZE(4), .T_PWR(10), .T_CMD(3), .T_CLR(6), .T_REFRESH(20), .CW(20)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ticks until a non-IDLE word appears; dc = cycles taken, -1 on timeout.
  task automatic next_word(input int budget, output logic [10:0] w, output int dc,
                           output logic ack);
    w = IDLE; dc = -1; ack = 1'b0;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (bus.o_comm !== IDLE) begin
        w = bus.o_comm; ack = bus.o_ack; dc = i;
        break;
      end
    end
  endtask

  task automatic expect_word(input string tag, input logic [10:0] exp_w,
                             input int exp_dc, input logic exp_ack);
    logic [10:0] w;
    int          dc;
    logic        ack;
    next_word(60, w, dc, ack);
    check({tag, "_word"}, 32'(w), 32'(exp_w));
    check({tag, "_ack"}, 32'(ack), 32'(exp_ack));
    if (exp_dc >= 0) check({tag, "_dist"}, 32'(dc), 32'(exp_dc));
  endtask

  // Holds reset, checks reset values, releases, then checks cycles 0..29.
  task automatic power_up(input string tag);
    logic [10:0] exp_c;
    bus.i_refresh_en = 1'b0;
    bus.i_req        = 1'b0;
    rst_n            = 1'b0;
    repeat (2) @(negedge clk);
    check({tag, "_rst_comm"}, 32'(bus.o_comm), 32'(IDLE));
    check({tag, "_rst_ack"}, 32'(bus.o_ack), 32'd0);
    check({tag, "_rst_ready"}, 32'(bus.o_ready), 32'd0);
    check({tag, "_rst_busy"}, 32'(bus.o_busy), 32'd1);
    rst_n = 1'b1;
    for (int c = 0; c < 30; c++) begin
      tick();
      case (c)
        10:      exp_c = 11'h038;
        13:      exp_c = 11'h00C;
        16:      exp_c = 11'h006;
        19:      exp_c = 11'h001;
        default: exp_c = IDLE;
      endcase
      check($sformatf("%s_comm_c%0d", tag, c), 32'(bus.o_comm), 32'(exp_c));
      check($sformatf("%s_ready_c%0d", tag, c), 32'(bus.o_ready), (c >= 25) ? 32'd1 : 32'd0);
    end
    check({tag, "_hub_busy"}, 32'(bus.o_busy), 32'd0);
  endtask

  initial begin
    logic [10:0] w;
    int          dc;
    logic        ack;

    bus.i_refresh_en = 1'b0;
    bus.i_addr       = 7'h00;
    bus.i_req        = 1'b0;
    bus.i_cmd        = 8'h00;

    power_up("pwr1");

    // Refresh frame; i_addr changed mid-frame shows up only in the next ADDR.
    bus.i_refresh_en = 1'b1;
    bus.i_addr       = 7'h40;
    expect_word("f1_addr", 11'h0C0, 1, 1'b0);
    bus.i_addr = 7'h05;
    expect_word("f1_s0", 11'h500, 3, 1'b0);
    expect_word("f1_s1", 11'h501, 3, 1'b0);
    expect_word("f1_s2", 11'h502, 3, 1'b0);
    expect_word("f1_s3", 11'h503, 3, 1'b0);
    expect_word("f2_addr", 11'h085, 24, 1'b0);

    // Refresh disabled mid-frame: frame completes, then nothing.
    bus.i_refresh_en = 1'b0;
    expect_word("f2_s0", 11'h500, 3, 1'b0);
    expect_word("f2_s1", 11'h501, 3, 1'b0);
    expect_word("f2_s2", 11'h502, 3, 1'b0);
    expect_word("f2_s3", 11'h503, 3, 1'b0);
    next_word(40, w, dc, ack);
    check("idle_no_word", 32'(w), 32'(IDLE));

    // Host commands: normal and clear spacing, request held while busy.
    bus.i_req = 1'b1;
    bus.i_cmd = 8'h0F;
    expect_word("u_0f", 11'h00F, 1, 1'b1);
    bus.i_cmd = 8'h01;
    check("u_busy", 32'(bus.o_busy), 32'd1);
    tick();
    check("u_ack_pulse", 32'(bus.o_ack), 32'd0);
    expect_word("u_01", 11'h001, 3, 1'b1);
    bus.i_cmd = 8'h0F;
    expect_word("u_after_clr", 11'h00F, 7, 1'b1);

    // Request and refresh due in the same HUB cycle: user word first.
    bus.i_refresh_en = 1'b1;
    bus.i_addr       = 7'h10;
    bus.i_cmd        = 8'h0C;
    expect_word("c_user", 11'h00C, 4, 1'b1);
    bus.i_req = 1'b0;
    expect_word("c_addr", 11'h090, 4, 1'b0);
    expect_word("c_s0", 11'h500, 3, 1'b0);
    expect_word("c_s1", 11'h501, 3, 1'b0);

    // Request raised mid-frame waits until all slots are written.
    bus.i_req = 1'b1;
    bus.i_cmd = 8'h06;
    expect_word("c_s2", 11'h502, 3, 1'b0);
    expect_word("c_s3", 11'h503, 3, 1'b0);
    expect_word("c_late_user", 11'h006, 4, 1'b1);
    bus.i_req = 1'b0;
    expect_word("c_next_addr", 11'h090, 24, 1'b0);
    expect_word("r_s0", 11'h500, 3, 1'b0);

    // Asynchronous reset mid-frame.
    rst_n = 1'b0;
    #1;
    check("r_comm", 32'(bus.o_comm), 32'(IDLE));
    check("r_ready", 32'(bus.o_ready), 32'd0);
    check("r_ack", 32'(bus.o_ack), 32'd0);
    power_up("pwr2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
